// File: rtl/camera_pkg.sv
// Shared types and constants for the camera exposure controller.
package camera_pkg;

  typedef enum logic [1:0] {Idle, Exposure, Readout} statetype;

  // Readout sequence: 6 phases, ADC strobe on phases 1 and 4.
  localparam int unsigned RD_LEN  = 6;
  localparam int unsigned ADC1_PH = 1;
  localparam int unsigned ADC2_PH = 4;

  typedef logic [2:0] phase_t;

  localparam phase_t RD_LAST  = phase_t'(RD_LEN - 1);
  localparam phase_t ADC1_P   = phase_t'(ADC1_PH);
  localparam phase_t ADC2_P   = phase_t'(ADC2_PH);
  localparam phase_t NRE1_BEG = phase_t'(ADC1_PH - 1);
  localparam phase_t NRE2_BEG = phase_t'(ADC2_PH - 1);

  // Default exposure-time settings.
  localparam int unsigned EXP_W_DEF     = 5;
  localparam int unsigned EXP_MIN_DEF   = 2;
  localparam int unsigned EXP_MAX_DEF   = 30;
  localparam int unsigned EXP_RESET_DEF = 10;

  // Row read enables are low for the ADC phase and the phase before it.
  function automatic logic nre1_low(input phase_t k);
    return (k == NRE1_BEG) || (k == ADC1_P);
  endfunction

  function automatic logic nre2_low(input phase_t k);
    return (k == NRE2_BEG) || (k == ADC2_P);
  endfunction

  function automatic logic adc_on(input phase_t k);
    return (k == ADC1_P) || (k == ADC2_P);
  endfunction

endpackage

// File: rtl/exposure_ctrl_if.sv
// Control buttons in, pixel-array/ADC strobes and status out.
interface exposure_ctrl_if #(
  parameter int unsigned EXP_W = 5
);
  logic             Init;
  logic             Exp_increase;
  logic             Exp_decrease;
  logic             Erase;
  logic             Expose;
  logic             NRE_1;
  logic             NRE_2;
  logic             ADC;
  logic             Busy;
  logic [EXP_W-1:0] Exp_time;

  modport master (
    output Init, Exp_increase, Exp_decrease,
    input  Erase, Expose, NRE_1, NRE_2, ADC, Busy, Exp_time
  );

  modport slave (
    input  Init, Exp_increase, Exp_decrease,
    output Erase, Expose, NRE_1, NRE_2, ADC, Busy, Exp_time
  );
endinterface

// File: rtl/exposure_timer.sv
// Loadable down-counter; Done while the count sits at zero.
module exposure_timer #(
  parameter int unsigned EXP_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [EXP_W-1:0] Load_val,
  output logic             Done
);
  logic [EXP_W-1:0] count;

  // Load beats counting; the count holds at zero until the next load.
  always_ff @(posedge Clk) begin
    if (Reset)
      count <= '0;
    else if (Load)
      count <= Load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign Done = (count == '0);
endmodule

// File: rtl/exposure_ctrl.sv
// Idle/Exposure/Readout sequencer for the pixel array and ADC.
module exposure_ctrl
  import camera_pkg::*;
#(
  parameter int unsigned EXP_W     = EXP_W_DEF,
  parameter int unsigned EXP_MIN   = EXP_MIN_DEF,
  parameter int unsigned EXP_MAX   = EXP_MAX_DEF,
  parameter int unsigned EXP_RESET = EXP_RESET_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  exposure_ctrl_if.slave bus
);
  localparam logic [EXP_W-1:0] MIN_V   = EXP_MIN[EXP_W-1:0];
  localparam logic [EXP_W-1:0] MAX_V   = EXP_MAX[EXP_W-1:0];
  localparam logic [EXP_W-1:0] RESET_V = EXP_RESET[EXP_W-1:0];

  statetype         state, nxt_state;
  phase_t           phase, nxt_phase;
  logic [EXP_W-1:0] exp_time, nxt_exp_time;
  logic             timer_load;
  logic             timer_done;

  // Timer counts exp_time-1 down to 0, giving exp_time Exposure cycles.
  exposure_timer #(.EXP_W(EXP_W)) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (timer_load),
    .Load_val (exp_time - 1'b1),
    .Done     (timer_done)
  );

  // Next state, readout phase, exposure-time adjust and timer load.
  always_comb begin
    nxt_state    = state;
    nxt_phase    = phase;
    nxt_exp_time = exp_time;
    timer_load   = 1'b0;
    case (state)
      Idle: begin
        if (bus.Init) begin
          timer_load = 1'b1;
          nxt_state  = Exposure;
        end else if (bus.Exp_increase && !bus.Exp_decrease) begin
          if (exp_time < MAX_V) nxt_exp_time = exp_time + 1'b1;
        end else if (bus.Exp_decrease && !bus.Exp_increase) begin
          if (exp_time > MIN_V) nxt_exp_time = exp_time - 1'b1;
        end
      end
      Exposure: begin
        if (timer_done) begin
          nxt_state = Readout;
          nxt_phase = '0;
        end
      end
      Readout: begin
        if (phase == RD_LAST) begin
          nxt_state = Idle;
          nxt_phase = '0;
        end else begin
          nxt_phase = phase + 1'b1;
        end
      end
      default: nxt_state = Idle;
    endcase
  end

  // State registers; outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= Idle;
      phase      <= '0;
      exp_time   <= RESET_V;
      bus.Erase  <= 1'b1;
      bus.Expose <= 1'b0;
      bus.NRE_1  <= 1'b1;
      bus.NRE_2  <= 1'b1;
      bus.ADC    <= 1'b0;
      bus.Busy   <= 1'b0;
    end else begin
      state      <= nxt_state;
      phase      <= nxt_phase;
      exp_time   <= nxt_exp_time;
      bus.Erase  <= (nxt_state == Idle);
      bus.Expose <= (nxt_state == Exposure);
      bus.NRE_1  <= !((nxt_state == Readout) && nre1_low(nxt_phase));
      bus.NRE_2  <= !((nxt_state == Readout) && nre2_low(nxt_phase));
      bus.ADC    <= (nxt_state == Readout) && adc_on(nxt_phase);
      bus.Busy   <= (nxt_state != Idle);
    end
  end

  assign bus.Exp_time = exp_time;
endmodule

// File: tb/tb_exposure_ctrl.sv
// Directed vector bench for exposure_ctrl plus a randomised invariant run.
module tb_exposure_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  exposure_ctrl_if #(.EXP_W(5)) bus ();

  exposure_ctrl #(
    .EXP_W     (5),
    .EXP_MIN   (2),
    .EXP_MAX   (30),
    .EXP_RESET (10)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst, init, inc, dec;
    logic       erase, expose, nre1, nre2, adc, busy;
    logic [4:0] exp_t;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic rst, init, inc, dec,
                              input logic erase, expose, nre1, nre2, adc, busy,
                              input int e);
    vec_t v;
    v.rst = rst; v.init = init; v.inc = inc; v.dec = dec;
    v.erase = erase; v.expose = expose; v.nre1 = nre1; v.nre2 = nre2;
    v.adc = adc; v.busy = busy; v.exp_t = 5'(e);
    vecs.push_back(v);
  endfunction

  function automatic void add_idle(input logic rst, init, inc, dec, input int e);
    add(rst, init, inc, dec, 1, 0, 1, 1, 0, 0, e);
  endfunction

  function automatic void add_exp(input logic init, inc, input int e);
    add(0, init, inc, 0, 0, 1, 1, 1, 0, 1, e);
  endfunction

  // Readout phase k: hand-tabulated NRE_1/NRE_2/ADC pattern.
  function automatic void add_rd(input int k, input logic init, inc, input int e);
    case (k)
      0: add(0, init, inc, 0, 0, 0, 0, 1, 0, 1, e);
      1: add(0, init, inc, 0, 0, 0, 0, 1, 1, 1, e);
      2: add(0, init, inc, 0, 0, 0, 1, 1, 0, 1, e);
      3: add(0, init, inc, 0, 0, 0, 1, 0, 0, 1, e);
      4: add(0, init, inc, 0, 0, 0, 1, 0, 1, 1, e);
      default: add(0, init, inc, 0, 0, 0, 1, 1, 0, 1, e);
    endcase
  endfunction

  // One full exposure+readout starting from Idle with Init asserted.
  function automatic void push_run(input int e, input logic first_inc,
                                   input logic hold_init, hold_inc);
    add_exp(1, first_inc, e);
    for (int i = 1; i < e; i++) add_exp(hold_init, hold_inc, e);
    for (int k = 0; k < 6; k++) add_rd(k, hold_init, hold_inc, e);
  endfunction

  task automatic step(input vec_t v, input string name, input int idx);
    logic [10:0] got, want;
    @(negedge Clk);
    Reset            = v.rst;
    bus.Init         = v.init;
    bus.Exp_increase = v.inc;
    bus.Exp_decrease = v.dec;
    @(posedge Clk);
    #1;
    got  = {bus.Erase, bus.Expose, bus.NRE_1, bus.NRE_2, bus.ADC, bus.Busy, bus.Exp_time};
    want = {v.erase, v.expose, v.nre1, v.nre2, v.adc, v.busy, v.exp_t};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d]: got erase/expose/nre1/nre2/adc/busy=%b exp=%0d, want %b exp=%0d",
               name, idx, got[10:5], got[4:0], want[10:5], want[4:0]);
    end
  endtask

  task automatic check_bit(input logic bad, input string name, input int cyc);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s at random cycle %0d: erase=%b expose=%b nre1=%b nre2=%b adc=%b exp=%0d",
               name, cyc, bus.Erase, bus.Expose, bus.NRE_1, bus.NRE_2, bus.ADC, bus.Exp_time);
    end
  endtask

  initial begin
    bus.Init = 1'b0;
    bus.Exp_increase = 1'b0;
    bus.Exp_decrease = 1'b0;

    // Reset then quiet idle.
    add_idle(1, 0, 0, 0, 10);
    for (int i = 0; i < 5; i++) add_idle(0, 0, 0, 0, 10);
    // Basic cycle at 10.
    push_run(10, 0, 0, 0);
    add_idle(0, 0, 0, 0, 10);
    // Saturating adjust.
    for (int i = 1; i <= 25; i++) add_idle(0, 0, 1, 0, (10 + i > 30) ? 30 : 10 + i);
    for (int i = 1; i <= 40; i++) add_idle(0, 0, 0, 1, (30 - i < 2) ? 2 : 30 - i);
    for (int i = 0; i < 3; i++) add_idle(0, 0, 1, 1, 2);
    // Minimum exposure.
    push_run(2, 0, 0, 0);
    add_idle(0, 0, 0, 0, 2);
    for (int i = 1; i <= 8; i++) add_idle(0, 0, 1, 0, 2 + i);
    // Inputs held through Exposure/Readout, Init held: back-to-back with
    // one Idle cycle; Init with Exp_increase in Idle leaves exp_time alone.
    push_run(10, 1, 1, 1);
    add_idle(0, 1, 1, 0, 10);
    push_run(10, 1, 0, 0);
    add_idle(0, 0, 0, 0, 10);

    foreach (vecs[i]) step(vecs[i], "vec", i);

    // Reset on the 4th Expose cycle after raising exp_time to 20.
    vecs.delete();
    for (int i = 1; i <= 10; i++) add_idle(0, 0, 1, 0, 10 + i);
    for (int i = 0; i < 4; i++) add_exp(i == 0, 0, 20);
    add_idle(1, 0, 0, 0, 10);
    add_idle(0, 0, 0, 0, 10);
    foreach (vecs[i]) step(vecs[i], "rst_expose", i);

    // Reset at readout k1 (ADC high, NRE_1 low).
    vecs.delete();
    for (int i = 0; i < 10; i++) add_exp(i == 0, 0, 10);
    add_rd(0, 0, 0, 10);
    add_rd(1, 0, 0, 10);
    add_idle(1, 0, 0, 0, 10);
    add_idle(0, 0, 0, 0, 10);
    foreach (vecs[i]) step(vecs[i], "rst_readout", i);

    // Random stimulus, invariants only.
    for (int c = 0; c < 10000; c++) begin
      @(negedge Clk);
      Reset            = ($urandom_range(0, 299) == 0);
      bus.Init         = ($urandom_range(0, 7) == 0);
      bus.Exp_increase = $urandom_range(0, 1) == 1;
      bus.Exp_decrease = $urandom_range(0, 1) == 1;
      @(posedge Clk);
      #1;
      check_bit(bus.Expose && bus.Erase, "expose_erase", c);
      check_bit(!bus.NRE_1 && !bus.NRE_2, "nre_both_low", c);
      check_bit(bus.ADC && bus.NRE_1 && bus.NRE_2, "adc_no_row", c);
      check_bit(bus.Exp_time < 5'd2 || bus.Exp_time > 5'd30, "exp_range", c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exposure_ctrl.md
Name: exposure_ctrl

Overview:
- Main sequencing FSM for the pixel-array camera controller: Idle (erase), Exposure, Readout.
- Owns and drives a loadable exposure timer sub-module.
- In Idle, holds a user-adjustable exposure time, changed with increase/decrease buttons.
- Generates Erase, Expose, NRE_1, NRE_2 and ADC strobes for the pixel array and ADC.

Parameters:
EXP_W, 5, width of exposure-time register and timer
EXP_MIN, 2, minimum exposure time in clock cycles
EXP_MAX, 30, maximum exposure time in clock cycles
EXP_RESET, 10, exposure time loaded on Reset

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Init  input  1  start exposure+readout cycle; level-sampled, acted on only in Idle
Exp_increase  input  1  +1 exposure time; acted on only in Idle
Exp_decrease  input  1  -1 exposure time; acted on only in Idle
Erase  output  1  pixel erase; high in Idle
Expose  output  1  pixel expose; high for exactly exp_time cycles
NRE_1  output  1  row-1 read enable, active low
NRE_2  output  1  row-2 read enable, active low
ADC  output  1  ADC convert strobe, 1-cycle pulses
Busy  output  1  high when not in Idle
Exp_time  output  EXP_W  current exposure-time register

Behaviour:
- All outputs are registered. States: Idle, Exposure, Readout.
- Reset (sampled at a Clk edge, any state, including mid-Exposure or mid-Readout) sets:
  - state=Idle, exp_time=EXP_RESET, timer cleared;
  - Erase=1, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0.
- Idle:
  - Erase=1, Expose=0, NRE_1=NRE_2=1, ADC=0, Busy=0.
  - Exp_increase only: exp_time+1, saturating at EXP_MAX.
  - Exp_decrease only: exp_time-1, saturating at EXP_MIN.
  - Both high: no change. Adjust is applied once per cycle while held (no edge detection).
  - Init high at edge N: load timer with exp_time; state=Exposure from cycle N+1.
  - Init and Exp_increase/decrease in the same cycle: Init wins, exp_time unchanged.
- Exposure:
  - Erase=0, Expose=1, Busy=1.
  - Expose is high for exactly exp_time cycles, counted by the timer.
  - On timer Done, go to Readout; Expose=0 in the first Readout cycle.
  - Init, Exp_increase and Exp_decrease are ignored.
- Readout: 6 cycles, phase counter k=0..5, Erase=0, Expose=0, Busy=1.
  - k0: NRE_1=0
  - k1: NRE_1=0, ADC=1
  - k2: NRE_1=1 (gap)
  - k3: NRE_2=0
  - k4: NRE_2=0, ADC=1
  - k5: all inactive
  - After k5, go to Idle. Inputs are ignored throughout Readout.
- Back-to-back operation:
  - Idle lasts at least 1 cycle (Erase=1 for at least one cycle).
  - If Init is still high in that cycle, a new Exposure starts the next cycle.
- Invariants:
  - Expose and Erase are never both 1.
  - NRE_1 and NRE_2 are never both 0.
  - ADC=1 only while one NRE is low.
- Width:
  - exp_time is always in [EXP_MIN, EXP_MAX], and EXP_MAX < 2^EXP_W.
  - Timer counts down from exp_time-1 to 0; Done is asserted while count==0.

Decomposition:
- camera_pkg holds:
  - typedef enum logic[1:0] {Idle, Exposure, Readout} statetype;
  - readout phase localparams (RD_LEN=6, ADC1_PH=1, ADC2_PH=4);
  - default EXP_MIN/EXP_MAX/EXP_RESET.
- Sub-module exposure_timer (Clk, Reset, Load, Load_val[EXP_W-1:0], Done):
  - synchronous loadable down-counter;
  - Load has priority over counting;
  - holds at 0 with Done=1 until the next Load.
- Readout phase counter stays inside exposure_ctrl.

Test Plan:
- Reset, then idle 5 cycles -> Exp_time=10, Erase=1, NRE_1=NRE_2=1, ADC=0, Busy=0.
- Init pulse at exp_time=10 -> Expose high exactly 10 cycles starting 1 cycle after Init; then NRE_1 low 2 cycles with ADC on the 2nd, 1 gap, NRE_2 low 2 cycles with ADC on the 2nd, 1 gap; then Erase=1.
- Exp_increase held 25 cycles from 10 -> Exp_time saturates at 30. Exp_decrease held 40 cycles -> saturates at 2. Both high together -> unchanged. Init with Exp_time=2 -> Expose high exactly 2 cycles.
- Exp_increase and Init high during Exposure or Readout -> Exp_time unchanged, no restart. Init held continuously -> Idle for exactly 1 cycle between cycles.
- Reset asserted on the 4th Expose cycle, after Exp_time was set to 20 -> next cycle Idle, Expose=0, Erase=1, Exp_time=10. Repeat with Reset at Readout k1 -> ADC=0, NRE_1=1 next cycle.
- Randomised inputs for 10k cycles -> assertions hold: Expose & Erase never both 1, NRE_1 and NRE_2 never both 0, Exp_time within [2,30].
